// File: rtl/spi_ram_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_pkg
// Shared types and constants for the SPI-attached command RAM.
//   cmd_t       : 2-bit command field carried in din[9:8]
//   CMD_*       : the four command encodings
//   dbg_t       : snapshot of the controller's address/armed registers,
//                 exported so checkers can observe internal sequencing state
// ---------------------------------------------------------------------------
package spi_ram_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    // Addresses are zero-extended to 8 bits so the layout does not depend
    // on the ADDR_SIZE parameter of a particular instance.
    typedef struct packed {
        logic [7:0] wr_addr;
        logic [7:0] rd_addr;
        logic       wr_armed;
        logic       rd_armed;
    } dbg_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_if
// Bus between the SPI slave (master side) and spi_ram_ctrl (slave side).
//   din      : 10-bit word, din[9:8] command, din[7:0] address/data
//   rx_valid : word-valid level from the SPI slave
//   dout     : read data back to the SPI slave
//   tx_valid : dout valid
//   seq_err  : one-cycle pulse on an illegal/out-of-range command
//   dbg      : controller address/armed registers
//
// Handshake: there is no ready. A word is taken exactly once, in the cycle
// where rx_valid is high and was low in the previous cycle; din must be
// stable in that cycle. tx_valid is a level that stays high until the next
// accepted word that is not a successful read-data.
// ---------------------------------------------------------------------------
interface spi_ram_ctrl_if;
    import spi_ram_pkg::*;

    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;
    dbg_t       dbg;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  seq_err,
        input  dbg
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output seq_err,
        output dbg
    );

endinterface

// File: rtl/sp_ram.sv
// ---------------------------------------------------------------------------
// sp_ram
// Single-port synchronous RAM, 8-bit words, registered read data.
//   clk   : clock
//   rst   : synchronous active-high reset, clears only the read register
//   en    : access enable
//   we    : write enable (with en); en without we is a read
//   addr  : word address
//   wdata : write data
//   rdata : read data, updated one clock after a read access and held
//           otherwise, so it can serve directly as an output register
// The array itself is never reset.
// ---------------------------------------------------------------------------
module sp_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (en && !we) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Command decoder in front of a single-port RAM, fed by an SPI slave.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset (memory contents preserved)
//   bus : spi_ram_ctrl_if.slave -- din/rx_valid in, dout/tx_valid/seq_err
//         and the dbg register snapshot out
// Commands (din[9:8]): 00 write-address, 01 write-data, 10 read-address,
// 11 read-data. Data accesses post-increment their address, wrapping at
// MEM_DEPTH-1, so one address command starts a burst.
// ---------------------------------------------------------------------------
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    localparam logic [8:0]           DEPTH_W   = 9'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    // Registers
    logic                 r_rx_valid_d;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_armed;
    logic                 r_rd_armed;
    logic                 r_tx_valid;
    logic                 r_seq_err;

    // Combinational next-state and RAM controls
    logic                 w_accept;
    cmd_t                 w_cmd;
    logic                 w_in_range;
    logic [ADDR_SIZE-1:0] w_addr_in;
    logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
    logic                 w_wr_armed_nxt;
    logic                 w_rd_armed_nxt;
    logic                 w_tx_valid_nxt;
    logic                 w_seq_err_nxt;
    logic                 w_ram_en;
    logic                 w_ram_we;
    logic [ADDR_SIZE-1:0] w_ram_addr;
    logic [7:0]           w_ram_rdata;
    dbg_t                 w_dbg;

    function automatic logic [ADDR_SIZE-1:0] f_next_addr(input logic [ADDR_SIZE-1:0] a);
        if (a == LAST_ADDR) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    // Rising edge of rx_valid only. Gated by rst so a word presented while
    // reset is asserted can never reach the RAM.
    assign w_accept   = bus.rx_valid && !r_rx_valid_d && !rst;
    assign w_cmd      = bus.din[9:8];
    assign w_in_range = ({1'b0, bus.din[7:0]} < DEPTH_W);
    assign w_addr_in  = bus.din[ADDR_SIZE-1:0];

    always_comb begin
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_wr_armed_nxt = r_wr_armed;
        w_rd_armed_nxt = r_rd_armed;
        w_tx_valid_nxt = r_tx_valid;
        w_seq_err_nxt  = 1'b0;
        w_ram_en       = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_addr     = r_rd_addr;

        if (w_accept) begin
            // Every accepted word drops tx_valid unless it is a successful
            // read-data, which re-asserts it below.
            w_tx_valid_nxt = 1'b0;
            case (w_cmd)
                CMD_WR_ADDR: begin
                    if (w_in_range) begin
                        w_wr_addr_nxt  = w_addr_in;
                        w_wr_armed_nxt = 1'b1;
                    end else begin
                        w_seq_err_nxt  = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (r_wr_armed) begin
                        w_ram_en      = 1'b1;
                        w_ram_we      = 1'b1;
                        w_ram_addr    = r_wr_addr;
                        w_wr_addr_nxt = f_next_addr(r_wr_addr);
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (w_in_range) begin
                        w_rd_addr_nxt  = w_addr_in;
                        w_rd_armed_nxt = 1'b1;
                    end else begin
                        w_seq_err_nxt  = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (r_rd_armed) begin
                        w_ram_en       = 1'b1;
                        w_ram_addr     = r_rd_addr;
                        w_tx_valid_nxt = 1'b1;
                        w_rd_addr_nxt  = f_next_addr(r_rd_addr);
                    end else begin
                        // Unarmed read leaves dout/tx_valid as they were.
                        w_tx_valid_nxt = r_tx_valid;
                        w_seq_err_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // rx_valid_d resets high so a level already high at release
            // is not mistaken for a new word.
            r_rx_valid_d <= 1'b1;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_armed   <= 1'b0;
            r_rd_armed   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_rx_valid_d <= bus.rx_valid;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_wr_armed   <= w_wr_armed_nxt;
            r_rd_armed   <= w_rd_armed_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_seq_err    <= w_seq_err_nxt;
        end
    end

    // The RAM read register doubles as the dout register: it only changes
    // on a read access, which gives the one-cycle read latency and holds
    // the last read value across other commands.
    sp_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_sp_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (bus.din[7:0]),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_dbg          = '0;
        w_dbg.wr_addr  = 8'(r_wr_addr);
        w_dbg.rd_addr  = 8'(r_rd_addr);
        w_dbg.wr_armed = r_wr_armed;
        w_dbg.rd_armed = r_rd_armed;
    end

    assign bus.dout     = w_ram_rdata;
    assign bus.tx_valid = r_tx_valid;
    assign bus.seq_err  = r_seq_err;
    assign bus.dbg      = w_dbg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_ctrl
// Two instances: dut_a (MEM_DEPTH 256) and dut_b (MEM_DEPTH 128, ADDR_SIZE 7).
// A table of spec vectors, hand-written multi-cycle sequences and a random
// phase checked against an array/queue reference model.
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_ctrl_if bus_a ();
    spi_ram_ctrl_if bus_b ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(7)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    // Reference model, index 0 = dut_a, 1 = dut_b
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wa [2];
    int         m_ra [2];
    bit         m_wv [2];
    bit         m_rv [2];
    bit         m_txv[2];
    logic [7:0] m_dout[2];
    bit         m_dknown[2];
    bit         m_seq[2];
    bit         m_rd_hit[2];

    // Outputs sampled in the cycle right after an accept
    logic [7:0] last_dout[2];
    logic       last_txv[2];
    logic       last_seq[2];

    typedef struct {
        logic [9:0] word;
        logic       seq;
        logic       txv;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wa[k]     = 0;
            m_ra[k]     = 0;
            m_wv[k]     = 1'b0;
            m_rv[k]     = 1'b0;
            m_txv[k]    = 1'b0;
            m_dout[k]   = 8'h00;
            m_dknown[k] = 1'b1;
            m_seq[k]    = 1'b0;
            m_rd_hit[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_apply(input int k, input logic [9:0] w);
        int depth = (k == 0) ? 256 : 128;
        int v     = int'(w[7:0]);
        m_seq[k]    = 1'b0;
        m_rd_hit[k] = 1'b0;
        case (w[9:8])
            2'b00: begin
                if (v < depth) begin m_wa[k] = v; m_wv[k] = 1'b1; end
                else m_seq[k] = 1'b1;
                m_txv[k] = 1'b0;
            end
            2'b01: begin
                if (m_wv[k]) begin
                    m_mem[k][m_wa[k]]   = w[7:0];
                    m_known[k][m_wa[k]] = 1'b1;
                    m_wa[k] = (m_wa[k] + 1) % depth;
                end else m_seq[k] = 1'b1;
                m_txv[k] = 1'b0;
            end
            2'b10: begin
                if (v < depth) begin m_ra[k] = v; m_rv[k] = 1'b1; end
                else m_seq[k] = 1'b1;
                m_txv[k] = 1'b0;
            end
            default: begin
                if (m_rv[k]) begin
                    m_dout[k]   = m_mem[k][m_ra[k]];
                    m_dknown[k] = m_known[k][m_ra[k]];
                    m_txv[k]    = 1'b1;
                    m_rd_hit[k] = 1'b1;
                    if (k == 0 && m_dknown[k]) exp_q.push_back(m_dout[k]);
                    m_ra[k] = (m_ra[k] + 1) % depth;
                end else m_seq[k] = 1'b1;
            end
        endcase
    endtask

    task automatic check_bus(input int k);
        logic [7:0] d;
        logic       t, s;
        dbg_t       g;
        logic [7:0] e;
        if (k == 0) begin d = bus_a.dout; t = bus_a.tx_valid; s = bus_a.seq_err; g = bus_a.dbg; end
        else        begin d = bus_b.dout; t = bus_b.tx_valid; s = bus_b.seq_err; g = bus_b.dbg; end
        last_dout[k] = d;
        last_txv[k]  = t;
        last_seq[k]  = s;
        chk($sformatf("seq_err[%0d]", k), 32'(s), 32'(m_seq[k]));
        chk($sformatf("tx_valid[%0d]", k), 32'(t), 32'(m_txv[k]));
        if (k == 0 && m_rd_hit[0] && m_dknown[0]) begin
            e = exp_q.pop_front();
            chk("dout_rd[0]", 32'(d), 32'(e));
        end else if (m_dknown[k]) begin
            chk($sformatf("dout[%0d]", k), 32'(d), 32'(m_dout[k]));
        end
        chk($sformatf("wr_addr[%0d]", k), 32'(g.wr_addr), 32'(m_wa[k]));
        chk($sformatf("rd_addr[%0d]", k), 32'(g.rd_addr), 32'(m_ra[k]));
        chk($sformatf("armed[%0d]", k), {30'b0, g.wr_armed, g.rd_armed}, {30'b0, m_wv[k], m_rv[k]});
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1 with rx_valid low at the previous edge. Raises
    // rx_valid for 'hold' cycles, checks after the accept edge, then drops it.
    task automatic send(input logic [9:0] w, input bit to_a, input bit to_b, input int hold);
        bus_a.din = w;  bus_b.din = w;
        bus_a.rx_valid = to_a;
        bus_b.rx_valid = to_b;
        @(posedge clk); #1;
        if (to_a) model_apply(0, w);
        if (to_b) model_apply(1, w);
        if (to_a) check_bus(0);
        if (to_b) check_bus(1);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            if (to_a) begin
                chk("hold_seq[0]", 32'(bus_a.seq_err), 32'd0);
                chk("hold_wr_addr[0]", 32'(bus_a.dbg.wr_addr), 32'(m_wa[0]));
            end
            if (to_b) chk("hold_seq[1]", 32'(bus_b.seq_err), 32'd0);
        end
        bus_a.rx_valid = 1'b0;
        bus_b.rx_valid = 1'b0;
        @(posedge clk); #1;
        if (to_a) chk("seq_width[0]", 32'(bus_a.seq_err), 32'd0);
        if (to_b) chk("seq_width[1]", 32'(bus_b.seq_err), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{10'h377, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{10'h005, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{10'h1A5, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{10'h205, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{10'h300, 1'b0, 1'b1, 8'hA5};
        tbl[5]  = '{10'h0FF, 1'b0, 1'b0, 8'hA5};
        tbl[6]  = '{10'h111, 1'b0, 1'b0, 8'hA5};
        tbl[7]  = '{10'h122, 1'b0, 1'b0, 8'hA5};
        tbl[8]  = '{10'h2FF, 1'b0, 1'b0, 8'hA5};
        tbl[9]  = '{10'h300, 1'b0, 1'b1, 8'h11};
        tbl[10] = '{10'h300, 1'b0, 1'b1, 8'h22};
        tbl[11] = '{10'h010, 1'b0, 1'b0, 8'h22};

        bus_a.din = '0; bus_a.rx_valid = 1'b0;
        bus_b.din = '0; bus_b.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus_a.dout), 32'd0);
        chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("rst_seq_err", 32'(bus_a.seq_err), 32'd0);
        chk("rst_dbg", 32'(bus_a.dbg), 32'd0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // ---- table: sequence error, basic write/read, burst wrap, tx clear
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].word, 1'b1, 1'b0, 1);
            chk($sformatf("tbl%0d_seq", i), 32'(last_seq[0]), 32'(tbl[i].seq));
            chk($sformatf("tbl%0d_txv", i), 32'(last_txv[0]), 32'(tbl[i].txv));
            chk($sformatf("tbl%0d_dout", i), 32'(last_dout[0]), 32'(tbl[i].dout));
        end

        // ---- level hold: exactly one write at addr 3
        send(10'h004, 1, 0, 1);
        send(10'h155, 1, 0, 1);
        send(10'h003, 1, 0, 1);
        send(10'h1C3, 1, 0, 20);
        chk("hold_wr_addr_after", 32'(bus_a.dbg.wr_addr), 32'd4);
        send(10'h203, 1, 0, 1);
        send(10'h300, 1, 0, 1);
        chk("hold_mem3", 32'(last_dout[0]), 32'hC3);
        send(10'h300, 1, 0, 1);
        chk("hold_mem4", 32'(last_dout[0]), 32'h55);

        // ---- MEM_DEPTH 128: range errors and wrap at 127
        send(10'h0C8, 0, 1, 1);
        chk("b_oor_seq", 32'(last_seq[1]), 32'd1);
        chk("b_oor_armed", 32'(bus_b.dbg.wr_armed), 32'd0);
        send(10'h280, 0, 1, 1);
        chk("b_rd_oor_seq", 32'(last_seq[1]), 32'd1);
        send(10'h07F, 0, 1, 1);
        chk("b_wa_127", 32'(bus_b.dbg.wr_addr), 32'h7F);
        send(10'h1AB, 0, 1, 1);
        send(10'h1CD, 0, 1, 1);
        chk("b_wa_wrap", 32'(bus_b.dbg.wr_addr), 32'd1);
        send(10'h27F, 0, 1, 1);
        send(10'h300, 0, 1, 1);
        chk("b_rd_127", 32'(last_dout[1]), 32'hAB);
        send(10'h300, 0, 1, 1);
        chk("b_rd_0", 32'(last_dout[1]), 32'hCD);
        chk("b_ra_wrap", 32'(bus_b.dbg.rd_addr), 32'd1);

        // ---- reset mid-burst with rx_valid held through release
        send(10'h205, 1, 0, 1);
        send(10'h300, 1, 0, 1);
        chk("pre_rst_dout", 32'(last_dout[0]), 32'hA5);
        bus_a.din = 10'h300;
        bus_a.rx_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_txv", 32'(bus_a.tx_valid), 32'd0);
        chk("mid_rst_armed", {30'b0, bus_a.dbg.wr_armed, bus_a.dbg.rd_armed}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_seq", 32'(bus_a.seq_err), 32'd0);
            chk("post_rst_txv", 32'(bus_a.tx_valid), 32'd0);
            chk("post_rst_dbg", 32'(bus_a.dbg), 32'd0);
        end
        bus_a.rx_valid = 1'b0;
        @(posedge clk); #1;
        send(10'h205, 1, 0, 1);
        send(10'h300, 1, 0, 1);
        chk("kept_mem5", 32'(last_dout[0]), 32'hA5);
        send(10'h2FF, 1, 0, 1);
        send(10'h300, 1, 0, 1);
        chk("kept_mem255", 32'(last_dout[0]), 32'h11);
        send(10'h300, 1, 0, 1);
        chk("kept_mem0", 32'(last_dout[0]), 32'h22);

        // ---- random phase on both instances
        for (int n = 0; n < 400; n++) begin
            logic [9:0] w;
            w = 10'($urandom_range(0, 1023));
            send(w, 1, 1, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
